// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and default baud-oversampling constants.
// Also used by uart_transmit.
package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;
   localparam int UART_MID_SAMPLE = UART_OVERSAMPLE/2 - 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

endpackage

// File: rtl/uart_receive_if.sv
// Receiver-side UART signal bundle: serial line in, byte/strobe/status out.
// Optional parity_err member present only when UART_RX_PARITY_EN is defined.
interface uart_receive_if #(
   parameter int DATA_BITS = 8
);

   logic                 rx_in;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_busy;
   logic                 frame_err;
`ifdef UART_RX_PARITY_EN
   logic                 parity_err;

   modport master (
      input  rx_in,
      output rx_data, rx_valid, rx_busy, frame_err, parity_err
   );

   modport slave (
      output rx_in,
      input  rx_data, rx_valid, rx_busy, frame_err, parity_err
   );
`else

   modport master (
      input  rx_in,
      output rx_data, rx_valid, rx_busy, frame_err
   );

   modport slave (
      output rx_in,
      input  rx_data, rx_valid, rx_busy, frame_err
   );
`endif

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the async serial line plus falling-edge detect.
// All flops reset to 1 (idle line), so a line held low never produces a fall.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx_in,
   output logic line_sync,
   output logic fall_pulse
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = rx_in;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign line_sync  = sync_q;
   assign fall_pulse = prev_q & ~sync_q;

endmodule

// File: rtl/uart_receive.sv
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), OVERSAMPLE clocks per bit.
// Emits one-cycle rx_valid / frame_err (/ parity_err) strobes after the stop-bit sample.
//
// state  | meaning
// IDLE   | waiting for a synchronised falling edge
// START  | timing to mid start bit; a high line there is a glitch
// DATA   | sampling DATA_BITS data bits, LSB first
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, then strobing the result
module uart_receive
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = UART_DATA_BITS
) (
   input  logic           clk,
   input  logic           rst,
   uart_receive_if.master rx_if
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE/2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic                 perr_q, perr_d;
   logic                 par_bad_q, par_bad_d;
`endif

   logic line_sync;
   logic fall_pulse;

   uart_rx_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .rx_in      (rx_if.rx_in),
      .line_sync  (line_sync),
      .fall_pulse (fall_pulse)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d    = 1'b0;
      par_bad_d = par_bad_q;
`endif
      case (state_q)
         IDLE: begin
            if (fall_pulse) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == CNT_MID) begin
               cnt_d = '0;
               if (!line_sync) begin
                  idx_d   = '0;
                  state_d = DATA;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {line_sync, shift_q[DATA_BITS-1:1]};
               if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               par_bad_d = line_sync ^ (^shift_q);
               state_d   = STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif
         STOP: begin
            // Leaving mid stop bit lets a back-to-back start edge be caught.
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (!line_sync) begin
                  ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (par_bad_q) begin
                  perr_d = 1'b1;
`endif
               end else begin
                  valid_d = 1'b1;
                  data_d  = shift_q;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q    <= 1'b0;
         par_bad_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         perr_q    <= perr_d;
         par_bad_q <= par_bad_d;
`endif
      end
   end

   assign rx_if.rx_data   = data_q;
   assign rx_if.rx_valid  = valid_q;
   assign rx_if.frame_err = ferr_q;
   assign rx_if.rx_busy   = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
   assign rx_if.parity_err = perr_q;
`endif

endmodule

// File: doc/uart_receive.md
Name: uart_receive

Overview:
- UART receiver; the stage directly downstream of uart_transmit. Deserialises its uart_tx line back into bytes.
- Runs on the same 16x-baud clock: 16 clocks per bit, 115200 baud nominal.
- Frame format: 8N1. One start bit (0), 8 data bits LSB first, one stop bit (1).
- Delivers each good byte with a one-cycle valid strobe and flags framing errors.

Parameters:
- OVERSAMPLE, 16, clocks per bit period; must be even and at least 4.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  16x-baud clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- rx_in  input  1  serial line; asynchronous to clk; idle high.
- rx_data  output  DATA_BITS  last correctly framed byte.
- rx_valid  output  1  one-cycle strobe: rx_data has just been updated.
- rx_busy  output  1  frame reception in progress.
- frame_err  output  1  one-cycle strobe: stop bit sampled as 0.

Behaviour:
- Synchroniser:
  - rx_in passes through 2 flops, both reset to 1.
  - A start is the synchronised falling edge: previous=1, current=0.
  - A line held low, e.g. a break, never retriggers reception.
- Reset values: rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, state=IDLE, counters=0.
- Reset mid-frame aborts the frame immediately; no strobe follows.
- State machine, 4 states; cnt is the sample counter and counts 0..OVERSAMPLE-1:
  - IDLE: on the falling edge, go to START with cnt=0.
  - START: at cnt=OVERSAMPLE/2-1 (mid start bit):
    - line still 0: cnt=0, bit index=0, go to DATA.
    - line 1: glitch; return to IDLE with no strobe.
  - DATA: at cnt=OVERSAMPLE-1, shift the sampled bit into the shift register MSB, shifting right (LSB first on the wire).
    - After bit index DATA_BITS-1, go to STOP.
  - STOP: at cnt=OVERSAMPLE-1, sample the line and return to IDLE.
    - 1: load rx_data from the shift register; rx_valid=1 for the next cycle only.
    - 0: frame_err=1 for the next cycle only; rx_data unchanged.
- rx_busy is 1 in START, DATA and STOP; 0 in IDLE.
- Timing, counted from the clock edge that enters START:
  - Data bit k is sampled at edge OVERSAMPLE/2 + OVERSAMPLE*(k+1).
  - The stop bit is sampled at edge 152 (default parameters).
  - rx_valid / frame_err are high during the cycle after that edge.
  - Pin-to-START adds 3 clocks: 2 synchroniser flops plus edge detect.
- Back-to-back frames:
  - IDLE is re-entered mid stop bit.
  - A start edge one half-bit later is caught with no lost frame.
- rx_valid and frame_err are mutually exclusive and never high on consecutive cycles.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampled at cnt=OVERSAMPLE-1; frame is 8E1.
  - Adds output parity_err (1 bit): one-cycle strobe, same timing as rx_valid, when received parity differs from even parity of the data.
  - On a parity error rx_data is not updated and rx_valid stays 0.
  - If stop=0 as well, only frame_err is raised.
  - Stop bit sampled at edge 168.
- Undefined: no PARITY state, no parity_err port; 8N1 as above.

Decomposition:
- Package uart_pkg:
  - State typedef {IDLE, START, DATA, PARITY, STOP}.
  - Constants UART_OVERSAMPLE=16, UART_DATA_BITS=8, UART_MID_SAMPLE=UART_OVERSAMPLE/2-1.
  - uart_transmit shares the same package.
- Sub-module uart_rx_sync:
  - 2-flop synchroniser plus falling-edge detect.
  - Outputs: line_sync, fall_pulse.
  - Reset-to-1 flops, same async active-low rst.

Test Plan:
- Reset: hold rst=0, toggle rx_in -> all outputs 0, no strobes; release, line idle high for 200 clocks -> outputs remain 0.
- Byte 0x75 in 8N1 at 16 clocks/bit -> rx_data=0x75; rx_valid high exactly 1 cycle, 155 clocks after the rx_in falling edge; rx_busy high throughout the frame; frame_err=0.
- Glitch: rx_in low for 4 clocks, then high -> no rx_valid, no frame_err; rx_busy returns to 0 within 10 clocks; rx_data unchanged.
- Framing error: send 0xA5 with stop bit forced 0 -> frame_err 1 cycle, rx_valid=0, rx_data keeps the previous 0x75; line held low afterwards (break) -> no further strobes.
- Back-to-back: 0x00, 0xFF, 0x3C with no idle gap between frames -> three rx_valid strobes with rx_data 0x00, 0xFF, 0x3C in order.
- Reset mid-frame: assert rst during data bit 3 of 0x55 -> all outputs 0 immediately; a subsequent clean 0xC3 is received correctly. With UART_RX_PARITY_EN: 0xC3 with odd parity bit -> parity_err 1 cycle, rx_valid=0.
